pl_hazard_ctrl: RTL and testbench
=================================

Name: pl_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage RV32I pipeline. It drives the stall (en) and flush (clr) inputs of the F/D, D/E, E/M and M/W pipeline registers, and produces the ALU operand forwarding selects. It also sequences multi-cycle data-memory accesses with a req/ack handshake: the whole pipeline is frozen until memory acknowledges, and a timeout watchdog bounds the wait.

Parameters:
MEM_TIMEOUT, 64, max wait cycles for dmem_ack before the error state; must be ≥2
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
Rs1D  in  5  rs1 field of instruction in Decode
Rs2D  in  5  rs2 field in Decode
Rs1E  in  5  rs1 in Execute
Rs2E  in  5  rs2 in Execute
RdE  in  5  rd in Execute
RdM  in  5  rd in Memory
RdW  in  5  rd in Writeback
ResultSrcE  in  2  2'b01 = load in Execute
RegWriteM  in  1  Memory-stage instruction writes rd
RegWriteW  in  1  Writeback-stage instruction writes rd
MemwriteM  in  1  store in Memory
ResultSrcM  in  2  2'b01 = load in Memory
PCSrcE  in  1  taken branch/jump resolved in Execute
dmem_ack  in  1  data memory completes the current access
dmem_req  out  1  data memory access request
ForwardAE  out  2  00 = regfile, 01 = ResultW, 10 = ALUResultM
ForwardBE  out  2  same encoding, operand B
StallF  out  1  1 = hold PC
StallD  out  1  1 = hold F/D register (its en)
StallE  out  1  1 = hold D/E register
StallM  out  1  1 = hold E/M register
FlushD  out  1  clr of F/D register
FlushE  out  1  clr of D/E register
FlushW  out  1  clr of M/W register (bubble while memory waits)
MemErr  out  1  sticky: memory timeout occurred
StallCnt  out  CNT_W  total cycles with StallF=1, saturating

Behaviour:
- FSM states: IDLE, WAIT, ERR. On rst_n=0 (asynchronous): state=IDLE, wait counter=0, MemErr=0, StallCnt=0. With state IDLE and all inputs 0, every output is 0.
- MemAccM = MemwriteM | (ResultSrcM==2'b01). dmem_req = MemAccM & (state≠ERR).
- IDLE:
  - If MemAccM & ~dmem_ack, go to WAIT and load wait counter = 1.
  - Ack in the same cycle is a zero-wait access: no stall, no state change.
- WAIT:
  - memStall = ~dmem_ack.
  - On dmem_ack, go to IDLE. Stall releases in the same cycle and the registers advance on that edge.
  - Otherwise the counter increments. When counter==MEM_TIMEOUT with no ack, go to ERR.
  - An ack on the timeout cycle itself wins, so the FSM goes to IDLE.
- ERR: memStall=1 permanently, MemErr=1. Leave only via reset.
- memStall is 1 when state is WAIT without ack, when state is ERR, or when state is IDLE with MemAccM & ~dmem_ack.
- lwStall = (ResultSrcE==2'b01) & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- Stall and flush outputs:
  - StallF = StallD = lwStall | memStall.
  - StallE = StallM = FlushW = memStall.
  - FlushD = PCSrcE & ~memStall.
  - FlushE = (lwStall | PCSrcE) & ~memStall.
  - memStall has priority: nothing is flushed while frozen, and the branch/load-use is re-evaluated after release.
- Forwarding (A shown; B identical using Rs2E):
  - 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Else 00. M takes priority over W. x0 is never forwarded.
- StallCnt increments on each rising edge where StallF=1, and saturates at all-ones.
- Stall, flush, forward and dmem_req outputs are combinational from inputs and state. MemErr and StallCnt are registered.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT → state IDLE, MemErr=0, StallCnt=0, all stalls 0 immediately, without waiting for a clock edge.
- Load-use: ResultSrcE=01, RdE=5, Rs2D=5 → StallF=StallD=FlushE=1 for one cycle, StallE=0. Repeat with RdE=0 → no stall.
- Forwarding: RdM=RdW=7, both RegWrite=1, Rs1E=7 → ForwardAE=10. Drop RegWriteM → 01. RdM=RdW=0 → 00.
- Branch: PCSrcE=1 with no memory access → FlushD=FlushE=1, no stalls.
- Branch during wait: PCSrcE=1 while in WAIT → FlushD=FlushE=0 until ack.
- Memory wait: MemwriteM=1, dmem_ack arrives on the 3rd cycle → dmem_req high for 3 cycles, StallF..M and FlushW=1 for 2 cycles, StallCnt=2.
- Zero-wait access: dmem_ack in the same cycle as the request → no stall.
- Timeout: MEM_TIMEOUT=4, ack never arrives → ERR after 4 WAIT cycles, MemErr=1, dmem_req=0, stalls held until reset. An ack on the 4th cycle instead returns the FSM to IDLE.

Source files
------------

// File: rtl/pl_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: load-use stalls,
// branch flushes, operand forwarding and a watchdog-guarded data-memory handshake.
module pl_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemwriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             PCSrcE,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [WCW-1:0]  r_waitCnt;
  logic [WCW-1:0]  w_nextWaitCnt;
  logic            r_memErr;
  logic [CNT_W-1:0] r_stallCnt;

  logic            w_memAccM;
  logic            w_memStall;
  logic            w_lwStall;
  logic            w_stallFD;

  assign w_memAccM = MemwriteM | (ResultSrcM == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
    end
  end

  // An ack always wins over the timeout check, even on the final wait cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    case (r_state)
      ST_IDLE: begin
        if (w_memAccM && !dmem_ack) begin
          w_nextState   = ST_WAIT;
          w_nextWaitCnt = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          w_nextState   = ST_IDLE;
          w_nextWaitCnt = '0;
        end else if (r_waitCnt == TIMEOUT_VAL) begin
          w_nextState = ST_ERR;
        end else begin
          w_nextWaitCnt = r_waitCnt + WCW'(1);
        end
      end
      ST_ERR: begin
        w_nextState = ST_ERR;
      end
      default: begin
        w_nextState   = ST_IDLE;
        w_nextWaitCnt = '0;
      end
    endcase
  end

  always_comb begin
    w_memStall = 1'b0;
    dmem_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_memStall = w_memAccM & ~dmem_ack;
        dmem_req   = w_memAccM;
      end
      ST_WAIT: begin
        w_memStall = ~dmem_ack;
        dmem_req   = w_memAccM;
      end
      ST_ERR: begin
        w_memStall = 1'b1;
        dmem_req   = 1'b0;
      end
      default: begin
        w_memStall = 1'b0;
        dmem_req   = 1'b0;
      end
    endcase
  end

  assign w_lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

  // A frozen pipeline must not lose the branch or load-use; both re-evaluate after release.
  assign w_stallFD = w_lwStall | w_memStall;
  assign StallF    = w_stallFD;
  assign StallD    = w_stallFD;
  assign StallE    = w_memStall;
  assign StallM    = w_memStall;
  assign FlushW    = w_memStall;
  assign FlushD    = PCSrcE & ~w_memStall;
  assign FlushE    = (w_lwStall | PCSrcE) & ~w_memStall;

  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic       regWriteM,
    input logic [4:0] rdM,
    input logic       regWriteW,
    input logic [4:0] rdW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
      sel = 2'b10;
    end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memErr <= 1'b0;
    end else if (w_nextState == ST_ERR) begin
      r_memErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (w_stallFD && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign MemErr   = r_memErr;
  assign StallCnt = r_stallCnt;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl with a short watchdog and a narrow stall counter
// so that timeout and saturation are both reachable.
module tb_pl_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE, ResultSrcM;
  logic             RegWriteM, RegWriteW, MemwriteM, PCSrcE, dmem_ack;
  logic             dmem_req;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCnt;

  int errors;
  int checks;

  pl_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemwriteM(MemwriteM), .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic memW, input logic [1:0] resM,
                               input logic ack, input logic br);
    MemwriteM  = memW;
    ResultSrcM = resM;
    dmem_ack   = ack;
    PCSrcE     = br;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE, ResultSrcM} = '0;
    {RegWriteM, RegWriteW, MemwriteM, PCSrcE, dmem_ack} = '0;
    #12;
    checkOutput("reset_ctl", 32'(ctl()), 32'h0);
    checkOutput("reset_req", 32'(dmem_req), 32'h0);
    checkOutput("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
    checkOutput("reset_memerr", 32'(MemErr), 32'h0);
    checkOutput("reset_cnt", 32'(StallCnt), 32'h0);
    rst_n = 1'b1;

    // Load-use hazard, then the same with rd = x0
    nextCycle();
    ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("loaduse_ctl", 32'(ctl()), 32'b1100010);
    nextCycle();
    checkOutput("loaduse_cnt", 32'(StallCnt), 32'd1);
    RdE = 5'd0; Rs2D = 5'd0;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("loaduse_x0_ctl", 32'(ctl()), 32'h0);
    nextCycle();
    checkOutput("loaduse_x0_cnt", 32'(StallCnt), 32'd1);
    ResultSrcE = 2'b00;

    // Forwarding priority and x0 suppression
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7; Rs2E = 5'd3;
    #1;
    checkOutput("fwd_A_mem", 32'(ForwardAE), 32'h2);
    checkOutput("fwd_B_none", 32'(ForwardBE), 32'h0);
    Rs2E = 5'd7;
    #1;
    checkOutput("fwd_B_mem", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0;
    #1;
    checkOutput("fwd_A_wb", 32'(ForwardAE), 32'h1);
    checkOutput("fwd_B_wb", 32'(ForwardBE), 32'h1);
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0; Rs2E = 5'd0;
    #1;
    checkOutput("fwd_x0", 32'({ForwardAE, ForwardBE}), 32'h0);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // Taken branch with no memory access
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("branch_ctl", 32'(ctl()), 32'b0000110);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Store with ack on the third cycle; branch arrives during the wait
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("memwait_c1_ctl", 32'(ctl()), 32'b1111001);
    checkOutput("memwait_c1_req", 32'(dmem_req), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
    checkOutput("memwait_c2_ctl", 32'(ctl()), 32'b1111001);
    checkOutput("memwait_c2_req", 32'(dmem_req), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1);
    checkOutput("memwait_c3_ctl", 32'(ctl()), 32'b0000110);
    checkOutput("memwait_c3_req", 32'(dmem_req), 32'h1);
    checkOutput("memwait_c3_cnt", 32'(StallCnt), 32'd3);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("memwait_done_ctl", 32'(ctl()), 32'h0);
    checkOutput("memwait_done_req", 32'(dmem_req), 32'h0);
    checkOutput("memwait_done_cnt", 32'(StallCnt), 32'd3);

    // Zero-wait load
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
    checkOutput("zerowait_req", 32'(dmem_req), 32'h1);
    checkOutput("zerowait_ctl", 32'(ctl()), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("zerowait_after_ctl", 32'(ctl()), 32'h0);
    checkOutput("zerowait_cnt", 32'(StallCnt), 32'd3);

    // Timeout into ERR
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("timeout_idle_ctl", 32'(ctl()), 32'b1111001);
    repeat (4) nextCycle();
    checkOutput("timeout_w4_memerr", 32'(MemErr), 32'h0);
    checkOutput("timeout_w4_req", 32'(dmem_req), 32'h1);
    nextCycle();
    checkOutput("err_memerr", 32'(MemErr), 32'h1);
    checkOutput("err_req", 32'(dmem_req), 32'h0);
    checkOutput("err_ctl", 32'(ctl()), 32'b1111001);
    checkOutput("err_cnt", 32'(StallCnt), 32'd8);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("err_branch_ctl", 32'(ctl()), 32'b1111001);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("err_ack_ctl", 32'(ctl()), 32'b1111001);
    checkOutput("err_ack_req", 32'(dmem_req), 32'h0);
    repeat (10) nextCycle();
    checkOutput("cnt_saturate", 32'(StallCnt), 32'd15);
    checkOutput("err_sticky", 32'(MemErr), 32'h1);

    // Asynchronous reset out of ERR
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_err_memerr", 32'(MemErr), 32'h0);
    checkOutput("rst_err_cnt", 32'(StallCnt), 32'h0);
    checkOutput("rst_err_ctl", 32'(ctl()), 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of WAIT
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    nextCycle();
    checkOutput("wait_before_rst_ctl", 32'(ctl()), 32'b1111001);
    rst_n = 1'b0;
    MemwriteM = 1'b0;
    #1;
    checkOutput("rst_wait_ctl", 32'(ctl()), 32'h0);
    checkOutput("rst_wait_cnt", 32'(StallCnt), 32'h0);
    checkOutput("rst_wait_memerr", 32'(MemErr), 32'h0);
    rst_n = 1'b1;

    // Ack on the final permitted wait cycle returns to IDLE
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (4) nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("ack_w4_ctl", 32'(ctl()), 32'h0);
    checkOutput("ack_w4_req", 32'(dmem_req), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("ack_w4_memerr", 32'(MemErr), 32'h0);
    checkOutput("ack_w4_newreq", 32'(dmem_req), 32'h1);
    checkOutput("ack_w4_newctl", 32'(ctl()), 32'b1111001);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
